// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game flow controller and the snake datapath / display.
// master drives the key and collision events, slave (the controller) drives status and pulses.
interface game_flow_ctrl_if;
  logic       key_start;
  logic       eat_food;
  logic       hit_wall;
  logic       hit_body;
  logic [1:0] game_status;
  logic       add_cube;
  logic       food_req;
  logic       move_tick;
  logic       die_flash;

  modport master (
    output key_start, eat_food, hit_wall, hit_body,
    input  game_status, add_cube, food_req, move_tick, die_flash
  );

  modport slave (
    input  key_start, eat_food, hit_wall, hit_body,
    output game_status, add_cube, food_req, move_tick, die_flash
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Snake game flow controller: RESTART/START/PLAY/DIE sequencing, move pacing and death blink.
// Optional macro SPEED_UP_EN shortens the move interval as cubes are eaten.
module game_flow_ctrl #(
  parameter int TICK_BASE    = 8,
  parameter int TICK_STEP    = 2,
  parameter int TICK_MIN     = 2,
  parameter int DIE_HOLD     = 16,
  parameter int FLASH_PERIOD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  game_flow_ctrl_if.slave gif
);
  localparam int TW = $clog2(TICK_BASE + 1);
  localparam int DW = $clog2(DIE_HOLD + 2);
  localparam int FW = $clog2(FLASH_PERIOD + 1);
  localparam logic [TW-1:0] TICK_BASE_C  = TW'(TICK_BASE);
  localparam logic [DW-1:0] DIE_HOLD_C   = DW'(DIE_HOLD);
  localparam logic [FW-1:0] FLASH_LAST_C = FW'(FLASH_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_RESTART = 2'b00,
    ST_START   = 2'b01,
    ST_PLAY    = 2'b10,
    ST_DIE     = 2'b11
  } state_t;

  if (TICK_MIN < 1 || TICK_MIN > TICK_BASE || TICK_STEP < 0) begin : g_param_check
    $error("game_flow_ctrl: TICK_MIN must lie in [1, TICK_BASE] and TICK_STEP must be >= 0");
  end

  state_t          state, state_nxt;
  logic            key_prev_p1;
  logic            key_rise, hit, in_play, eat_ok, mv_wrap, die_held;
  logic [TW-1:0]   mv_cnt, interval;
  logic [DW-1:0]   die_cnt;
  logic [FW-1:0]   flash_cnt;

  assign key_rise = gif.key_start & ~key_prev_p1;
  assign hit      = gif.hit_wall | gif.hit_body;
  assign in_play  = (state == ST_PLAY);
  assign eat_ok   = in_play & gif.eat_food & ~hit;
  assign mv_wrap  = (mv_cnt == interval - TW'(1));
  assign die_held = (die_cnt >= DIE_HOLD_C);

  assign gif.game_status = state;

`ifdef SPEED_UP_EN
  logic [6:0]    eaten;
  logic [TW-1:0] interval_q;

  function automatic logic [TW-1:0] calc_interval(input logic [6:0] n);
    int v;
    v = TICK_BASE - TICK_STEP * (int'(n) / 10);
    if (v < TICK_MIN) v = TICK_MIN;
    return TW'(v);
  endfunction

  function automatic logic [6:0] sat_eaten(input logic [6:0] n);
    return (n >= 7'd99) ? 7'd99 : n + 7'd1;
  endfunction

  // Interval only changes at a period boundary so a running period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eaten      <= '0;
      interval_q <= TICK_BASE_C;
    end else begin
      if (state == ST_RESTART) eaten <= '0;
      else if (eat_ok)         eaten <= sat_eaten(eaten);
      if (!in_play || mv_wrap) interval_q <= calc_interval(eaten);
    end
  end

  assign interval = interval_q;
`else
  assign interval = TICK_BASE_C;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESTART;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESTART: state_nxt = ST_START;
      ST_START:   if (key_rise) state_nxt = ST_PLAY;
      ST_PLAY:    if (hit) state_nxt = ST_DIE;
      ST_DIE:     if (key_rise && die_held) state_nxt = ST_RESTART;
      default:    state_nxt = ST_RESTART;
    endcase
  end

  // Registered outputs; a hit suppresses the same-cycle tick so pulses never leak into DIE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_p1   <= 1'b1;
      mv_cnt        <= '0;
      die_cnt       <= '0;
      flash_cnt     <= '0;
      gif.add_cube  <= 1'b0;
      gif.food_req  <= 1'b0;
      gif.move_tick <= 1'b0;
      gif.die_flash <= 1'b0;
    end else begin
      key_prev_p1   <= gif.key_start;
      gif.add_cube  <= eat_ok;
      gif.food_req  <= eat_ok;
      gif.move_tick <= in_play & ~hit & mv_wrap;

      if (!in_play || mv_wrap) mv_cnt <= '0;
      else                     mv_cnt <= mv_cnt + TW'(1);

      if (state_nxt != ST_DIE) begin
        die_cnt       <= '0;
        flash_cnt     <= '0;
        gif.die_flash <= 1'b0;
      end else if (state != ST_DIE) begin
        die_cnt       <= '0;
        flash_cnt     <= '0;
        gif.die_flash <= 1'b1;
      end else begin
        if (!die_held) die_cnt <= die_cnt + DW'(1);
        if (flash_cnt == FLASH_LAST_C) begin
          flash_cnt     <= '0;
          gif.die_flash <= ~gif.die_flash;
        end else begin
          flash_cnt <= flash_cnt + FW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomised scoreboard bench for game_flow_ctrl against a cycle-count based reference model.
module tb_game_flow_ctrl;
  localparam int TB_BASE  = 8;
  localparam int TB_HOLD  = 16;
  localparam int TB_FLASH = 4;
`ifdef SPEED_UP_EN
  localparam int TB_STEP  = 2;
  localparam int TB_MIN   = 2;
`endif
  localparam logic [1:0] S_RESTART = 2'b00;
  localparam logic [1:0] S_START   = 2'b01;
  localparam logic [1:0] S_PLAY    = 2'b10;
  localparam logic [1:0] S_DIE     = 2'b11;

  typedef struct {
    logic [1:0] st;
    logic       add;
    logic       food;
    logic       tick;
    logic       flash;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  game_flow_ctrl_if gif();

  game_flow_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (gif)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [1:0] m_st;
  logic       m_last_key;
  int         cyc;
  int         m_next_tick;
  int         m_die_entry;
  int         m_eaten;

  function automatic int f_interval();
`ifdef SPEED_UP_EN
    int v;
    v = TB_BASE - TB_STEP * (m_eaten / 10);
    return (v < TB_MIN) ? TB_MIN : v;
`else
    return TB_BASE;
`endif
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  // Monitor: every negedge, compare DUT outputs with the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("game_status", int'(gif.game_status), int'(e.st),    e.cyc);
      chk("add_cube",    int'(gif.add_cube),    int'(e.add),   e.cyc);
      chk("food_req",    int'(gif.food_req),    int'(e.food),  e.cyc);
      chk("move_tick",   int'(gif.move_tick),   int'(e.tick),  e.cyc);
      chk("die_flash",   int'(gif.die_flash),   int'(e.flash), e.cyc);
    end
  end

  task automatic model_reset();
    m_st       = S_RESTART;
    m_last_key = 1'b1;
    m_eaten    = 0;
  endtask

  task automatic push_reset_expect();
    exp_t x;
    x.st = S_RESTART; x.add = 1'b0; x.food = 1'b0; x.tick = 1'b0; x.flash = 1'b0;
    x.cyc = cyc;
    sb.push_back(x);
  endtask

  // Drive one cycle of inputs, predict the next cycle's outputs, then advance past the edge.
  task automatic step(input logic k, input logic e, input logic w, input logic b);
    exp_t x;
    logic rise, hit;
    logic [1:0] nst;
    gif.key_start = k;
    gif.eat_food  = e;
    gif.hit_wall  = w;
    gif.hit_body  = b;
    rise = k && !m_last_key;
    hit  = w || b;
    x.add = 1'b0; x.food = 1'b0; x.tick = 1'b0; x.flash = 1'b0;
    nst = m_st;
    case (m_st)
      S_RESTART: nst = S_START;
      S_START: if (rise) begin
        nst = S_PLAY;
        m_next_tick = cyc + 1 + f_interval();
      end
      S_PLAY: if (hit) nst = S_DIE;
      else begin
        if (e) begin x.add = 1'b1; x.food = 1'b1; end
        if (cyc + 1 == m_next_tick) begin
          x.tick = 1'b1;
          m_next_tick = cyc + 1 + f_interval();
        end
      end
      S_DIE: if (rise && (cyc - m_die_entry) >= TB_HOLD) nst = S_RESTART;
      default: nst = S_RESTART;
    endcase
    if (nst == S_DIE) begin
      if (m_st != S_DIE) m_die_entry = cyc + 1;
      x.flash = ((((cyc + 1 - m_die_entry) / TB_FLASH) % 2) == 0);
    end
    if (m_st == S_RESTART) m_eaten = 0;
    else if (x.add && m_eaten < 99) m_eaten++;
    x.st  = nst;
    x.cyc = cyc + 1;
    sb.push_back(x);
    m_st       = nst;
    m_last_key = k;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    gif.key_start = 1'b1;
    gif.eat_food  = 1'b0;
    gif.hit_wall  = 1'b0;
    gif.hit_body  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_status",    int'(gif.game_status), int'(S_RESTART), cyc);
    chk("async_add_cube",  int'(gif.add_cube),  0, cyc);
    chk("async_food_req",  int'(gif.food_req),  0, cyc);
    chk("async_move_tick", int'(gif.move_tick), 0, cyc);
    chk("async_die_flash", int'(gif.die_flash), 0, cyc);
    sb.delete();
    model_reset();
    push_reset_expect();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int   guard;
    int   len;
    int   idx;
    logic k;
    gif.key_start = 1'b1;
    gif.eat_food  = 1'b0;
    gif.hit_wall  = 1'b0;
    gif.hit_body  = 1'b0;
    rst_n = 1'b0;
    cyc = 0;
    m_next_tick = 0;
    m_die_entry = 0;
    model_reset();
    #1;
    push_reset_expect();
    #6;
    rst_n = 1'b1;

    // Key held high through reset must not start the game.
    for (int i = 0; i < 3; i++) step(1'b1, rb(), rb(), rb());

    for (int g = 0; g < 6; g++) begin
      guard = 0;
      while (m_st != S_START && guard < 8) begin
        step(1'b1, rb(), rb(), rb());
        guard++;
      end
      step(1'b0, rb(), rb(), rb());
      step(1'b1, rb(), rb(), rb());

      len = $urandom_range(40, 140);
      for (int i = 0; i < len; i++)
        step(rb(), (g % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0),
             1'b0, 1'b0);

      if (g == 3) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        async_reset();
      end else begin
        if (g == 0) step(1'b0, 1'b1, 1'b0, 1'b1);
        else        step(1'b0, rb(), (g % 2 == 1), (g % 2 == 0));
        for (int i = 0; i < 80 && m_st == S_DIE; i++) begin
          idx = cyc - m_die_entry;
          if (g == 0) k = ((idx >= 5 && idx < 8) || idx >= 20);
          else        k = (idx < TB_HOLD) ? rb() : (idx >= TB_HOLD + 3);
          step(k, rb(), rb(), rb());
        end
      end
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TICK_BASE, default 8, sets the move interval in clk cycles at zero cubes eaten.
REQ-002 Parameter TICK_STEP, default 2, sets the interval decrement per speed level (SPEED_UP_EN only).
REQ-003 Parameter TICK_MIN, default 2, sets the minimum move interval in cycles; TICK_MIN SHALL be at least 1 and no greater than TICK_BASE.
REQ-004 Parameter DIE_HOLD, default 16, sets the minimum cycles spent in DIE before a restart is accepted.
REQ-005 Parameter FLASH_PERIOD, default 4, sets the cycles between die_flash toggles.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_start  input  1  debounced start/restart key, level; action on rising edge only.
REQ-009 eat_food  input  1  one-cycle pulse: snake head reached food.
REQ-010 hit_wall  input  1  one-cycle pulse: head collided with boundary.
REQ-011 hit_body  input  1  one-cycle pulse: head collided with own body.
REQ-012 game_status  output  2  RESTART=00, START=01, PLAY=10, DIE=11; drives the score counter and the snake datapath.
REQ-013 add_cube  output  1  one-cycle pulse: grow snake and increment score.
REQ-014 food_req  output  1  one-cycle pulse: request new food placement.
REQ-015 move_tick  output  1  one-cycle pulse: advance snake one cell.
REQ-016 die_flash  output  1  blink enable for the display while in DIE.

Function
REQ-017 key_start rising edge is detected against a registered previous value; a key held through reset SHALL NOT count as an edge.
REQ-018 RESTART SHALL last exactly one cycle, then go to START.
REQ-019 START SHALL wait for a key_start rising edge, then go to PLAY; eat/hit inputs SHALL be ignored in START.
REQ-020 In PLAY, a hit_wall or hit_body pulse SHALL move the FSM to DIE on the next edge.
REQ-021 In PLAY, an eat_food pulse without a hit SHALL produce add_cube and food_req pulses in the following cycle (1-cycle latency).
REQ-022 If eat_food and a hit occur in the same cycle, the hit SHALL win: go to DIE, with no add_cube and no food_req.
REQ-023 The move counter SHALL clear on PLAY entry; move_tick SHALL pulse when the counter reaches interval-1, then wrap to 0, so the first tick comes interval cycles after entry.
REQ-024 move_tick, add_cube and food_req SHALL be 0 in every state other than PLAY.
REQ-025 An internal eaten counter SHALL clear in RESTART, increment on each accepted eat, and saturate at 99.
REQ-026 In DIE, die_flash SHALL toggle every FLASH_PERIOD cycles starting from 1 at DIE entry, and SHALL be 0 in all other states.
REQ-027 In DIE, a key_start rising edge SHALL go to RESTART only after DIE_HOLD cycles in DIE; earlier edges SHALL be discarded.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL asynchronously force game_status=RESTART, add_cube=0, food_req=0, move_tick=0, die_flash=0, all counters to 0, and the key edge register to 1.
REQ-030 Reset asserted mid-PLAY or mid-DIE SHALL abort the game; after release, the block behaves exactly as after power-up.

Configuration
REQ-031 Macro SPEED_UP_EN defined: interval = max(TICK_BASE - TICK_STEP*(eaten/10), TICK_MIN), re-evaluated when the counter wraps.
REQ-032 SPEED_UP_EN undefined: interval is fixed at TICK_BASE, and the speed logic and eaten counter are not present.

Verification (default parameters)
REQ-033 Reset release, key low, then key rising edge -> RESTART for 1 cycle, START, then PLAY one cycle after the edge; first move_tick 8 cycles after PLAY entry, then every 8 cycles.
REQ-034 eat_food pulse in PLAY -> add_cube=1 and food_req=1 for exactly 1 cycle, one cycle later.
REQ-035 eat_food and hit_body in the same cycle -> DIE next cycle; add_cube stays 0.
REQ-036 In DIE, key edge at cycle 5 -> ignored; key edge at cycle 20 -> RESTART, then START; die_flash pattern 1111000011110000 from DIE entry.
REQ-037 SPEED_UP_EN with 10 eats -> interval 6; with 30 eats -> interval 2 (floor); without SPEED_UP_EN, interval stays 8.
REQ-038 rst_n pulsed low mid-PLAY -> all outputs 0 and game_status=00 immediately, without waiting for clk.
